// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the sequential multiplier and divider.
package fxp_pkg;

    localparam int FXP_WIDTH = 32;
    localparam int FXP_FRAC  = 15;

    localparam logic [FXP_WIDTH-1:0] FXP_MAX = {1'b0, {(FXP_WIDTH-1){1'b1}}};
    localparam logic [FXP_WIDTH-1:0] FXP_MIN = {1'b1, {(FXP_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Caller sign-extends to 64 bits; |-2^(W-1)| stays representable as unsigned.
    function automatic logic [63:0] fxp_abs(input logic signed [63:0] v);
        return v[63] ? 64'(-v) : 64'(v);
    endfunction

endpackage

// File: rtl/fxp_rescale_sat.sv
// Drops FRAC_BITS from a 2W-bit product magnitude, applies sign and saturates.
module fxp_rescale_sat
    import fxp_pkg::*;
#(
    parameter int WIDTH     = FXP_WIDTH,
    parameter int FRAC_BITS = FXP_FRAC
) (
    input  logic [2*WIDTH-1:0] mag,
    input  logic               sign,
    output logic [WIDTH-1:0]   res,
    output logic               ovf
);

    localparam logic [2*WIDTH-1:0] POS_LIM = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [2*WIDTH-1:0] NEG_LIM = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0] q;

    always_comb begin
        q   = mag >> FRAC_BITS;
        res = sign ? -q[WIDTH-1:0] : q[WIDTH-1:0];
        ovf = 1'b0;
        if (!sign && q > POS_LIM) begin
            res = {1'b0, {(WIDTH-1){1'b1}}};
            ovf = 1'b1;
        end else if (sign && q > NEG_LIM) begin
            res = {1'b1, {(WIDTH-1){1'b0}}};
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/fixed_mult_seq.sv
// Sequential signed fixed-point multiplier: radix-2 shift-add, one multiplier bit per clock.
module fixed_mult_seq
    import fxp_pkg::*;
#(
    parameter int WIDTH     = FXP_WIDTH,
    parameter int FRAC_BITS = FXP_FRAC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               sign;
    logic [WIDTH-1:0]   sat_res;
    logic               sat_ovf;

    fxp_rescale_sat #(
        .WIDTH    (WIDTH),
        .FRAC_BITS(FRAC_BITS)
    ) u_sat (
        .mag (acc),
        .sign(sign),
        .res (sat_res),
        .ovf (sat_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            res   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            mag_a <= '0;
            mag_b <= '0;
            sign  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sign  <= a[WIDTH-1] ^ b[WIDTH-1];
                        mag_a <= (2*WIDTH)'(fxp_abs(64'($signed(a))));
                        mag_b <= WIDTH'(fxp_abs(64'($signed(b))));
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                // mag_a<<cnt and mag_b[cnt] realised by shifting the operand registers.
                RUN: begin
                    if (mag_b[0]) acc <= acc + mag_a;
                    mag_a <= mag_a << 1;
                    mag_b <= mag_b >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIN;
                end
                FIN: begin
                    res   <= sat_res;
                    ovf   <= sat_ovf;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_mult_seq.sv
// Randomised and directed checks of fixed_mult_seq against an arithmetic reference model.
module tb_fixed_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, ovf;
    logic [31:0] res;

    int tests = 0;
    int fails = 0;

    fixed_mult_seq #(.WIDTH(32), .FRAC_BITS(15)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .res  (res),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Exact signed product, truncated toward zero, saturated to Q17.15.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic o);
        longint          p;
        longint unsigned m, q;
        bit              neg;
        p   = longint'($signed(x)) * longint'($signed(y));
        neg = (p < 0);
        m   = neg ? longint'(-p) : longint'(p);
        q   = m >> 15;
        o   = 1'b0;
        if (!neg && q > 64'h7FFF_FFFF) begin
            r = 32'h7FFF_FFFF; o = 1'b1;
        end else if (neg && q > 64'h8000_0000) begin
            r = 32'h8000_0000; o = 1'b1;
        end else begin
            r = neg ? 32'(-q) : 32'(q);
        end
    endfunction

    // One operation; optionally disturbs start/a/b after 'poke' cycles in RUN.
    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input logic eo, input int poke);
        int lat, bcnt;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            if (lat == poke) begin
                start = 1'b1; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'd33);
        check({tag, "_busy"}, 32'(bcnt), 32'd33);
        check({tag, "_res"}, res, er);
        check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
        @(negedge clk);
        check({tag, "_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_hold"}, res, er);
    endtask

    initial begin
        logic [31:0] x, y, er;
        logic        eo, seen;
        int          t[3];
        int          nd, cyc;

        // Reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (busy || done || ovf || res != 0) seen = 1'b1;
        end
        check("idle_outputs", {31'b0, seen}, 32'd0);

        // Directed vectors
        run_op("mul_5x2",     32'h0002_8000, 32'h0001_0000, 32'h0005_0000, 1'b0, -1);
        run_op("mul_n15x25",  32'hFFFF_4000, 32'h0001_4000, 32'hFFFE_2000, 1'b0, -1);
        run_op("mul_n15xn25", 32'hFFFF_4000, 32'hFFFE_C000, 32'h0001_E000, 1'b0, -1);
        run_op("sat_pos",     32'h4E20_0000, 32'h4E20_0000, 32'h7FFF_FFFF, 1'b1, -1);
        run_op("sat_neg",     32'h4E20_0000, 32'hB1E0_0000, 32'h8000_0000, 1'b1, -1);
        run_op("trunc_pos",   32'h0000_0001, 32'h0000_4000, 32'h0000_0000, 1'b0, -1);
        run_op("trunc_neg",   32'hFFFF_FFFF, 32'h0000_4000, 32'h0000_0000, 1'b0, -1);
        run_op("min_x_one",   32'h8000_0000, 32'h0000_8000, 32'h8000_0000, 1'b0, -1);
        run_op("min_x_min",   32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, -1);

        // Start pulse and operand changes mid-run are ignored
        run_op("ignore_mid",  32'h0002_8000, 32'h0001_0000, 32'h0005_0000, 1'b0, 10);

        // Randomised operands of varied magnitude
        for (int i = 0; i < 40; i++) begin
            x = $urandom >> $urandom_range(0, 31);
            y = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) x = -x;
            if ($urandom_range(0, 1) == 1) y = -y;
            model(x, y, er, eo);
            run_op("rand", x, y, er, eo, -1);
        end

        // Reset mid-run discards the operation
        @(negedge clk);
        a = 32'h0002_8000; b = 32'h0001_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_abort_res", res, er);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_res",  res, 32'd0);
        check("abort_ovf",  {31'b0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("abort_no_done", {31'b0, seen}, 32'd0);

        // Start held high: one result every 34 cycles
        a = 32'h0002_8000; b = 32'h0001_0000; start = 1'b1;
        nd = 0; cyc = 0;
        while (nd < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                t[nd] = cyc;
                nd++;
                check("held_res", res, 32'h0005_0000);
            end
        end
        start = 1'b0;
        check("held_count", 32'(nd), 32'd3);
        if (nd == 3) begin
            check("held_period1", 32'(t[1] - t[0]), 32'd34);
            check("held_period2", 32'(t[2] - t[1]), 32'd34);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
